// File: rtl/avsdpll_pkg.sv
// Shared types and default parameters for the PLL digital lock detector.
package avsdpll_pkg;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MULT     = 8;
    localparam int unsigned TOL      = 1;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned TIMEOUT  = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

endpackage

// File: rtl/avsdpll_ref_sync.sv
// Brings the asynchronous reference into the CLK domain and flags its rising edges.
module avsdpll_ref_sync (
    input  logic clk,
    input  logic rst,
    input  logic ref_in,
    output logic ref_rise_c
);

    logic [2:0] sync_d;
    logic [2:0] sync_q;

    // Two metastability stages followed by an edge-detect stage.
    always_comb begin
        sync_d = {sync_q[1:0], ref_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ref_rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/avsdpll_lock_det.sv
// Lock detector: measures CLK cycles per REF period, declares lock after a run
// of in-tolerance periods and flags a missing reference.
module avsdpll_lock_det #(
    parameter int unsigned CNT_W    = avsdpll_pkg::CNT_W,
    parameter int unsigned MULT     = avsdpll_pkg::MULT,
    parameter int unsigned TOL      = avsdpll_pkg::TOL,
    parameter int unsigned LOCK_CNT = avsdpll_pkg::LOCK_CNT,
    parameter int unsigned TIMEOUT  = avsdpll_pkg::TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             REF,
    output logic             LOCK,
    output logic             REF_LOST,
    output logic             MEAS_VALID,
    output logic [CNT_W-1:0] MEAS_CNT
);

    import avsdpll_pkg::*;

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned DIFF_W = CNT_W + 1;

    state_t              state_d, state_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [GOOD_W-1:0]   good_d, good_q;
    logic                lock_d, lock_q;
    logic                ref_lost_d, ref_lost_q;
    logic                meas_valid_d, meas_valid_q;
    logic [CNT_W-1:0]    meas_cnt_d, meas_cnt_q;

    logic                ref_rise_c;
    logic [DIFF_W-1:0]   cnt_ext_c;
    logic [DIFF_W-1:0]   diff_c;
    logic                period_good_c;
    logic                timeout_c;
    logic [GOOD_W-1:0]   good_inc_c;

    avsdpll_ref_sync u_ref_sync (
        .clk        (CLK),
        .rst        (RST),
        .ref_in     (REF),
        .ref_rise_c (ref_rise_c)
    );

    // Period classification and saturating good-period increment.
    always_comb begin
        cnt_ext_c     = {1'b0, cnt_q};
        diff_c        = (cnt_ext_c >= DIFF_W'(MULT)) ? (cnt_ext_c - DIFF_W'(MULT))
                                                     : (DIFF_W'(MULT) - cnt_ext_c);
        period_good_c = (diff_c <= DIFF_W'(TOL));
        timeout_c     = (cnt_q == CNT_W'(TIMEOUT));
        good_inc_c    = (good_q == GOOD_W'(LOCK_CNT)) ? good_q : (good_q + GOOD_W'(1));
    end

    // Next state and outputs; a coincident edge takes priority over timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        good_d       = good_q;
        lock_d       = lock_q;
        ref_lost_d   = ref_lost_q;
        meas_valid_d = 1'b0;
        meas_cnt_d   = meas_cnt_q;

        if (!EN) begin
            state_d    = IDLE;
            cnt_d      = '0;
            good_d     = '0;
            lock_d     = 1'b0;
            ref_lost_d = 1'b0;
            meas_cnt_d = '0;
        end else begin
            if (state_q != IDLE) begin
                if (ref_rise_c) begin
                    cnt_d = CNT_W'(1);
                end else if (!timeout_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (ref_rise_c) begin
                        state_d    = MEASURE;
                        ref_lost_d = 1'b0;
                    end else if (timeout_c) begin
                        ref_lost_d = 1'b1;
                        lock_d     = 1'b0;
                        good_d     = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (ref_rise_c) begin
                        meas_valid_d = 1'b1;
                        meas_cnt_d   = cnt_q;
                        ref_lost_d   = 1'b0;
                        if (period_good_c) begin
                            good_d = good_inc_c;
                            if (good_inc_c == GOOD_W'(LOCK_CNT)) begin
                                state_d = LOCKED;
                                lock_d  = 1'b1;
                            end
                        end else begin
                            good_d  = '0;
                            lock_d  = 1'b0;
                            state_d = MEASURE;
                        end
                    end else if (timeout_c) begin
                        ref_lost_d = 1'b1;
                        lock_d     = 1'b0;
                        good_d     = '0;
                        state_d    = ACQUIRE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            good_q       <= '0;
            lock_q       <= 1'b0;
            ref_lost_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            good_q       <= good_d;
            lock_q       <= lock_d;
            ref_lost_q   <= ref_lost_d;
            meas_valid_q <= meas_valid_d;
            meas_cnt_q   <= meas_cnt_d;
        end
    end

    assign LOCK       = lock_q;
    assign REF_LOST   = ref_lost_q;
    assign MEAS_VALID = meas_valid_q;
    assign MEAS_CNT   = meas_cnt_q;

endmodule

// File: tb/tb_avsdpll_lock_det.sv
// Scenario bench for avsdpll_lock_det: a period model feeds a scoreboard of
// expected measurements, scenario tasks check timing-specific behaviour inline.
`timescale 1ns/1ps
module tb_avsdpll_lock_det;

    localparam int unsigned CNT_W = 8;
    localparam int MULT     = 8;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             lock;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST;
    logic             EN;
    logic             REF;
    logic             LOCK;
    logic             REF_LOST;
    logic             MEAS_VALID;
    logic [CNT_W-1:0] MEAS_CNT;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    bit   m_acq    = 1'b1;
    int   m_good   = 0;
    bit   m_lock   = 1'b0;
    int   prev_len = 0;

    avsdpll_lock_det dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .REF        (REF),
        .LOCK       (LOCK),
        .REF_LOST   (REF_LOST),
        .MEAS_VALID (MEAS_VALID),
        .MEAS_CNT   (MEAS_CNT)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every measurement pulse must match the oldest expected entry.
    always @(negedge CLK) begin
        if (MEAS_VALID === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL meas_unexpected: t=%0t MEAS_CNT=%0d LOCK=%b, no measurement expected",
                         $time, MEAS_CNT, LOCK);
            end else begin
                mon_e = exp_q.pop_front();
                if (MEAS_CNT !== mon_e.cnt || LOCK !== mon_e.lock) begin
                    n_err++;
                    $display("FAIL meas_scoreboard: t=%0t got cnt=%0d lock=%b, expected cnt=%0d lock=%b",
                             $time, MEAS_CNT, LOCK, mon_e.cnt, mon_e.lock);
                end
            end
        end
    end

    // Reference behaviour at each REF rising edge.
    function automatic void model_edge(input int p);
        int   d;
        exp_t e;
        if (m_acq) begin
            m_acq = 1'b0;
        end else begin
            d = (prev_len >= MULT) ? (prev_len - MULT) : (MULT - prev_len);
            if (d <= TOL) begin
                if (m_good < LOCK_CNT) m_good++;
                if (m_good == LOCK_CNT) m_lock = 1'b1;
            end else begin
                m_good = 0;
                m_lock = 1'b0;
            end
            e.cnt  = CNT_W'(prev_len);
            e.lock = m_lock;
            exp_q.push_back(e);
        end
        prev_len = p;
    endfunction

    function automatic void model_clear();
        m_acq  = 1'b1;
        m_good = 0;
        m_lock = 1'b0;
    endfunction

    // One REF period of p CLK cycles, starting with a rising edge at a negedge.
    task automatic pulse(input int p);
        model_edge(p);
        REF = 1'b1;
        repeat (p / 2) @(negedge CLK);
        REF = 1'b0;
        repeat (p - p / 2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        EN  = 1'b0;
        REF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if ({LOCK, REF_LOST, MEAS_VALID, MEAS_CNT} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: cycle %0d lock=%b lost=%b valid=%b cnt=%0d, expected all 0",
                         i, LOCK, REF_LOST, MEAS_VALID, MEAS_CNT);
            end
        end
        RST = 1'b0;
        EN  = 1'b1;
        model_clear();
        pulse(8);
        model_edge(8);
        REF = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (MEAS_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: MEAS_VALID=%b two cycles after REF rise, expected 0", MEAS_VALID);
        end
        @(negedge CLK);
        n_checks++;
        if (MEAS_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL latency_edge: MEAS_VALID=%b three cycles after REF rise, expected 1", MEAS_VALID);
        end
        @(negedge CLK);
        n_checks++;
        if (MEAS_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL valid_one_cycle: MEAS_VALID=%b on second cycle, expected 0", MEAS_VALID);
        end
        REF = 1'b0;
        repeat (4) @(negedge CLK);
        pulse(8);
        pulse(8);
        n_checks++;
        if (LOCK !== 1'b0) begin
            n_err++;
            $display("FAIL lock_early: LOCK=%b after 3 good periods, expected 0", LOCK);
        end
        pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL first_lock: LOCK=%b after 5 REF edges, expected 1", LOCK);
        end
    endtask

    task automatic test_tolerance();
        int pl [11];
        pl = '{7, 9, 7, 9, 10, 8, 8, 8, 8, 6, 8};
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        for (int i = 0; i < 11; i++) begin
            pulse(pl[i]);
            if (i == 4 || i == 9) begin
                n_checks++;
                if (LOCK !== 1'b1) begin
                    n_err++;
                    $display("FAIL tol_lock: after period index %0d LOCK=%b, expected 1", i, LOCK);
                end
            end
            if (i == 5 || i == 10) begin
                n_checks++;
                if (LOCK !== 1'b0) begin
                    n_err++;
                    $display("FAIL tol_unlock: after period index %0d LOCK=%b, expected 0", i, LOCK);
                end
            end
        end
    endtask

    task automatic test_ref_loss();
        repeat (5) pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL loss_prelock: LOCK=%b, expected 1", LOCK);
        end
        repeat (249) @(negedge CLK);
        n_checks++;
        if (REF_LOST !== 1'b0 || LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL loss_early: lost=%b lock=%b one cycle before timeout, expected lost=0 lock=1",
                     REF_LOST, LOCK);
        end
        @(negedge CLK);
        n_checks++;
        if (REF_LOST !== 1'b1 || LOCK !== 1'b0) begin
            n_err++;
            $display("FAIL loss_flag: lost=%b lock=%b at timeout, expected lost=1 lock=0", REF_LOST, LOCK);
        end
        model_clear();
        pulse(8);
        n_checks++;
        if (REF_LOST !== 1'b0) begin
            n_err++;
            $display("FAIL loss_clear: REF_LOST=%b after new REF edge, expected 0", REF_LOST);
        end
    endtask

    task automatic test_simultaneous();
        repeat (4) pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL simul_prelock: LOCK=%b, expected 1", LOCK);
        end
        pulse(255);
        pulse(8);
        n_checks++;
        if (REF_LOST !== 1'b0 || LOCK !== 1'b0 || MEAS_CNT !== 8'd255) begin
            n_err++;
            $display("FAIL simul_edge: lost=%b lock=%b cnt=%0d, expected lost=0 lock=0 cnt=255",
                     REF_LOST, LOCK, MEAS_CNT);
        end
    endtask

    task automatic test_enable_drop();
        repeat (4) pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL en_prelock: LOCK=%b, expected 1", LOCK);
        end
        EN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if ({LOCK, REF_LOST, MEAS_VALID, MEAS_CNT} !== '0) begin
            n_err++;
            $display("FAIL en_drop: lock=%b lost=%b valid=%b cnt=%0d, expected all 0",
                     LOCK, REF_LOST, MEAS_VALID, MEAS_CNT);
        end
        EN = 1'b1;
        model_clear();
        repeat (4) pulse(8);
        n_checks++;
        if (LOCK !== 1'b0) begin
            n_err++;
            $display("FAIL en_relock_early: LOCK=%b after 4 edges, expected 0", LOCK);
        end
        pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL en_relock: LOCK=%b after 5 edges, expected 1", LOCK);
        end
    endtask

    task automatic test_reset_mid();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        repeat (4) pulse(8);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({LOCK, REF_LOST, MEAS_VALID, MEAS_CNT} !== '0) begin
            n_err++;
            $display("FAIL rst_mid: lock=%b lost=%b valid=%b cnt=%0d, expected all 0",
                     LOCK, REF_LOST, MEAS_VALID, MEAS_CNT);
        end
        RST = 1'b0;
        model_clear();
        repeat (4) pulse(8);
        n_checks++;
        if (LOCK !== 1'b0) begin
            n_err++;
            $display("FAIL rst_relock_early: LOCK=%b after 4 edges, expected 0", LOCK);
        end
        pulse(8);
        n_checks++;
        if (LOCK !== 1'b1) begin
            n_err++;
            $display("FAIL rst_relock: LOCK=%b after 5 edges, expected 1", LOCK);
        end
    endtask

    initial begin
        test_reset();
        test_tolerance();
        test_ref_loss();
        test_simultaneous();
        test_enable_drop();
        test_reset_mid();
        repeat (5) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL meas_missing: %0d expected measurements never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/avsdpll_lock_det.md
# avsdpll_lock_det

Digital lock detector downstream of the analog PLL macro, clocked directly by the PLL `CLK` output. It synchronises the same `REF` reference fed to the PLL and counts `CLK` cycles per `REF` period. After `LOCK_CNT` consecutive periods within tolerance of the expected multiplication ratio, it asserts `LOCK`. It flags loss of reference and publishes each measured period for the management SoC.

## Interface
Parameters:
- `CNT_W`, 8: period counter width.
- `MULT`, 8: expected `CLK` cycles per `REF` period. Range 2..2^CNT_W-1.
- `TOL`, 1: allowed absolute deviation from `MULT`, in cycles.
- `LOCK_CNT`, 4: consecutive good periods required for lock. Minimum 1.
- `TIMEOUT`, 255: cycles without a `REF` edge before `REF_LOST`. Must satisfy `MULT+TOL` < `TIMEOUT` ≤ 2^CNT_W-1.

Ports:
- `CLK` in 1: PLL output clock; the only clock.
- `RST` in 1: reset, synchronous, active-high.
- `EN` in 1: detector enable; synchronous to `CLK`.
- `REF` in 1: reference clock, asynchronous to `CLK`.
- `LOCK` out 1: PLL locked.
- `REF_LOST` out 1: no `REF` edge seen for `TIMEOUT` cycles.
- `MEAS_VALID` out 1: one-cycle pulse; `MEAS_CNT` is updated.
- `MEAS_CNT` out CNT_W: last measured period in `CLK` cycles.

## Operation
- **Synchroniser.** `REF` passes through a 2-flop synchroniser and then a third flop. `ref_rise` = sync2 & ~sync3.
- **Period counter.** Set to 1 on `ref_rise`; otherwise increments, saturating at `TIMEOUT`. The measured period is the counter value in the cycle where `ref_rise` is high.
- **Tolerance check.** A period is good when |cnt − MULT| ≤ TOL. The difference is computed unsigned at CNT_W+1 bits as (cnt ≥ MULT ? cnt−MULT : MULT−cnt).
- **`good_cnt` counter.** Saturating counter, 0..LOCK_CNT. A good period increments it; a bad period clears it.

State machine:
- **IDLE.** Entered on `RST` or `EN`=0. Counters cleared; all outputs 0. Goes to ACQUIRE when `EN`=1.
- **ACQUIRE.** Waits for the first `ref_rise`. That edge produces no measurement; it starts the counter and moves to MEASURE.
- **MEASURE.** Each `ref_rise`:
  - Registers `MEAS_CNT` and pulses `MEAS_VALID`.
  - Updates `good_cnt`.
  - Moves to LOCKED when `good_cnt` reaches `LOCK_CNT`; `LOCK` rises in the same cycle as that `MEAS_VALID`.
- **LOCKED.** A good period keeps the state. A bad period clears `LOCK` and `good_cnt` in the `MEAS_VALID` cycle and returns to MEASURE.
- **Timeout** (any of ACQUIRE, MEASURE, LOCKED). When the counter equals `TIMEOUT` with no `ref_rise`:
  - `REF_LOST` goes to 1; `LOCK` and `good_cnt` go to 0.
  - State goes to ACQUIRE.
  - `REF_LOST` is cleared by the next `ref_rise`.

Boundary rules:
- `ref_rise` and counter==`TIMEOUT` in the same cycle: the edge wins and is measured normally (bad by construction); no `REF_LOST`.
- `EN` falling mid-operation: IDLE next cycle, all outputs 0.
- `RST` overrides `EN`.
- In ACQUIRE the counter still runs, so a missing `REF` is detected.

## Timing
- Reset values: `LOCK`=0, `REF_LOST`=0, `MEAS_VALID`=0, `MEAS_CNT`=0, state IDLE.
- All outputs are registered.
- `REF` rising, sampled at `CLK` edge k, produces `ref_rise` in the cycle after edge k+1. `MEAS_VALID`, `MEAS_CNT`, `LOCK` and `REF_LOST` update at edge k+2.
- `MEAS_VALID` is high for exactly one cycle per measured edge.
- `MEAS_CNT` holds its value between pulses.
- First `LOCK`: `LOCK_CNT` good periods after the ACQUIRE edge, i.e. (LOCK_CNT+1) `REF` edges.

## Structure
- Shared package `avsdpll_pkg`:
  - State typedef: `IDLE`, `ACQUIRE`, `MEASURE`, `LOCKED`.
  - Default parameter constants: `CNT_W`, `MULT`, `TOL`, `LOCK_CNT`, `TIMEOUT`.
- One sub-module, `avsdpll_ref_sync`: 2-flop synchroniser plus edge detect, outputting `ref_rise`.

## Test plan
All scenarios use default parameters.
- **Reset and idle.** `RST` for 3 cycles, then `EN`=1 with `REF` toggling every 4 `CLK` (period 8) → all outputs 0 during reset. First `MEAS_VALID` carries `MEAS_CNT`=8. `LOCK`=1 on the 4th `MEAS_VALID` (5th `REF` edge).
- **Tolerance edges.** Periods 7, 9, 7, 9 → all good, `LOCK`=1. A following period of 10 → `LOCK`=0 in that `MEAS_VALID` cycle; four further periods of 8 are needed to relock.
- **Reference loss.** While locked, hold `REF` low → exactly 255 cycles after the last `ref_rise`, `REF_LOST`=1 and `LOCK`=0. The next `REF` rise clears `REF_LOST` with no `MEAS_VALID`.
- **Simultaneous edge and timeout.** `ref_rise` coincides with counter=255 → `MEAS_VALID` with `MEAS_CNT`=255, `REF_LOST` stays 0, `LOCK`=0.
- **Enable drop mid-lock.** `EN`=0 for 1 cycle while locked → all outputs 0 next cycle. Re-enable → ACQUIRE, relock after 5 `REF` edges.
- **Reset mid-measurement.** Assert `RST` while `good_cnt`=3 → outputs 0 next cycle. After release, the full `LOCK_CNT` sequence is required again.
